// File: rtl/wreg_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// wreg_ctrl_pkg
// Shared types and constants for the systolic-array weight-load controller.
//   wreg_ctrl_state_t : controller FSM states (IDLE, CLEAR, LOAD, HOLD)
//   STALL_CNT_W       : width of the optional stall counter
// ----------------------------------------------------------------------------
package wreg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_HOLD
    } wreg_ctrl_state_t;

    localparam int STALL_CNT_W = 16;

endpackage : wreg_ctrl_pkg

// File: rtl/wreg_load_ctrl.sv
// ----------------------------------------------------------------------------
// wreg_load_ctrl
// Sequences weight loading into one systolic-array column whose weight
// registers form a shift chain with shared enable / clear / data. A (re)load
// clears the column for one cycle, then shifts in ROWS beats taken from a
// valid/ready source. The set is flagged stable (o_loaded) and held until
// compute releases it or a new load is requested.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           request a (re)load of the column
//   i_abort           abandon the current operation and clear the column
//   i_release         compute has finished with the loaded weights
//   i_w_valid/i_w_data, o_w_ready   weight beat handshake (signed data)
//   o_wreg_en         shift enable to the weight-register chain
//   o_wreg_clr        synchronous clear to the weight-register chain
//   o_wreg_data       data into the head of the chain
//   o_row_idx         beats accepted in the current load
//   o_busy            controller is clearing or loading
//   o_loaded          column holds a complete, stable weight set
//
// Build option:
//   WREG_LOAD_CTRL_PERF_EN  adds o_stall_cnt, a saturating count of LOAD
//                           cycles where the controller was ready but no
//                           beat was offered; cleared on entering CLEAR.
// ----------------------------------------------------------------------------
module wreg_load_ctrl
    import wreg_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ROWS  = 8,
    parameter int IDX_W = $clog2(ROWS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_release,
    input  logic                    i_w_valid,
    input  logic signed [WIDTH-1:0] i_w_data,
    output logic                    o_w_ready,
    output logic                    o_wreg_en,
    output logic                    o_wreg_clr,
    output logic signed [WIDTH-1:0] o_wreg_data,
    output logic [IDX_W-1:0]        o_row_idx,
    output logic                    o_busy,
    output logic                    o_loaded
`ifdef WREG_LOAD_CTRL_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0]  o_stall_cnt
`endif
);

    localparam logic [IDX_W-1:0] ROWS_IDX = IDX_W'(ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    wreg_ctrl_state_t        state_q, state_d;
    logic [IDX_W-1:0]        row_idx_q, row_idx_d;
    logic                    wreg_en_q, wreg_en_d;
    logic                    wreg_clr_q, wreg_clr_d;
    logic signed [WIDTH-1:0] wreg_data_q, wreg_data_d;
    logic                    loaded_q, loaded_d;

    logic w_ready;
    logic accept;

    // Ready is withheld during an abort so a beat offered in that cycle is
    // never consumed by the source and then silently dropped here.
    assign w_ready = (state_q == ST_LOAD) && (row_idx_q < ROWS_IDX) && !i_abort;
    assign accept  = w_ready && i_w_valid;

    // NOTE: every combinational output gets a default first, so no path
    // through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_LOAD;
            ST_LOAD:  if (accept && (row_idx_q == LAST_IDX)) state_d = ST_HOLD;
            ST_HOLD: begin
                // A new load outranks a release arriving in the same cycle.
                if (i_start)        state_d = ST_CLEAR;
                else if (i_release) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (i_abort) state_d = ST_IDLE;

        row_idx_d = row_idx_q;
        if (i_abort || (state_d == ST_CLEAR)) row_idx_d = '0;
        else if (accept)                      row_idx_d = row_idx_q + IDX_W'(1);

        // Output register stage: a beat accepted now shifts next cycle.
        wreg_en_d   = accept;
        wreg_data_d = accept ? i_w_data : wreg_data_q;

        // Clear is pulsed for the CLEAR cycle and for the cycle after an
        // abort. Neither can coincide with an accept, so en and clr stay
        // mutually exclusive.
        wreg_clr_d = i_abort || (state_d == ST_CLEAR);

        // Stable only once HOLD has lasted past its entry cycle, i.e. after
        // the final shift has landed in the chain.
        loaded_d = (state_q == ST_HOLD) && (state_d == ST_HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_idx_q   <= '0;
            wreg_en_q   <= 1'b0;
            wreg_clr_q  <= 1'b0;
            wreg_data_q <= '0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            wreg_en_q   <= wreg_en_d;
            wreg_clr_q  <= wreg_clr_d;
            wreg_data_q <= wreg_data_d;
            loaded_q    <= loaded_d;
        end
    end

`ifdef WREG_LOAD_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_d == ST_CLEAR)
            stall_cnt_d = '0;
        else if (w_ready && !i_w_valid && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

    assign o_w_ready   = w_ready;
    assign o_wreg_en   = wreg_en_q;
    assign o_wreg_clr  = wreg_clr_q;
    assign o_wreg_data = wreg_data_q;
    assign o_row_idx   = row_idx_q;
    assign o_busy      = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    assign o_loaded    = loaded_q;

endmodule : wreg_load_ctrl

// File: tb/tb_wreg_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wreg_load_ctrl
// Self-checking bench for wreg_load_ctrl (WIDTH=16, ROWS=8). Holds a
// cycle-level behavioural model of the load protocol plus a model of the
// weight-register column driven by the DUT's en/clr/data outputs.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wreg_load_ctrl;

    localparam int WIDTH = 16;
    localparam int ROWS  = 8;
    localparam int IDX_W = $clog2(ROWS + 1);

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_LOAD  = 2;
    localparam int P_HOLD  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0, i_abort = 1'b0, i_release = 1'b0, i_w_valid = 1'b0;
    logic [WIDTH-1:0] i_w_data = '0;
    logic             o_w_ready, o_wreg_en, o_wreg_clr, o_busy, o_loaded;
    logic [WIDTH-1:0] o_wreg_data;
    logic [IDX_W-1:0] o_row_idx;
`ifdef WREG_LOAD_CTRL_PERF_EN
    logic [15:0]      o_stall_cnt;
`endif

    wreg_load_ctrl #(.WIDTH(WIDTH), .ROWS(ROWS), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_release   (i_release),
        .i_w_valid   (i_w_valid),
        .i_w_data    (i_w_data),
        .o_w_ready   (o_w_ready),
        .o_wreg_en   (o_wreg_en),
        .o_wreg_clr  (o_wreg_clr),
        .o_wreg_data (o_wreg_data),
        .o_row_idx   (o_row_idx),
        .o_busy      (o_busy),
        .o_loaded    (o_loaded)
`ifdef WREG_LOAD_CTRL_PERF_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_phase = P_IDLE;
    int               m_cnt = 0;
    bit               m_en = 0, m_clr = 0, m_loaded = 0, m_set_valid = 0;
    logic [WIDTH-1:0] m_data = '0;
    int               m_stall = 0;
    logic [WIDTH-1:0] m_beats[$];
    logic [WIDTH-1:0] chain[ROWS];

    task automatic model_reset();
        m_phase = P_IDLE; m_cnt = 0; m_en = 0; m_clr = 0; m_loaded = 0;
        m_set_valid = 0; m_data = '0; m_stall = 0; m_beats.delete();
    endtask

    task automatic check_chain(input string name);
        bit ok = 1;
        for (int i = 0; i < ROWS; i++)
            if (m_beats.size() != ROWS || chain[i] !== m_beats[ROWS-1-i]) ok = 0;
        check(name, ok, 1);
    endtask

    // One clock cycle: drive inputs, check ready mid-cycle, advance the
    // model across the edge, then check all registered outputs.
    task automatic cycle(input bit st, input bit ab, input bit rl, input bit vl,
                         input logic [WIDTH-1:0] d, output bit rdy_seen);
        bit exp_ready, acc;
        int nxt;
        i_start = st; i_abort = ab; i_release = rl; i_w_valid = vl; i_w_data = d;
        @(negedge clk);
        rdy_seen  = o_w_ready;
        exp_ready = (m_phase == P_LOAD) && (m_cnt < ROWS) && !ab;
        check("ready", o_w_ready, exp_ready);
        check("clr_en_excl", o_wreg_clr & o_wreg_en, 0);
        // column model: applies whatever the DUT drives at the coming edge
        if (o_wreg_clr) begin
            for (int i = 0; i < ROWS; i++) chain[i] = '0;
        end else if (o_wreg_en) begin
            for (int i = ROWS - 1; i > 0; i--) chain[i] = chain[i-1];
            chain[0] = o_wreg_data;
        end
        acc = exp_ready && vl;
        if (ab) nxt = P_IDLE;
        else if (m_phase == P_IDLE)  nxt = st ? P_CLEAR : P_IDLE;
        else if (m_phase == P_CLEAR) nxt = P_LOAD;
        else if (m_phase == P_LOAD)  nxt = (acc && m_beats.size() + 1 == ROWS) ? P_HOLD : P_LOAD;
        else                         nxt = st ? P_CLEAR : (rl ? P_IDLE : P_HOLD);
        m_en = acc;
        if (acc) begin m_data = d; m_beats.push_back(d); end
        m_clr    = ab || (nxt == P_CLEAR);
        m_loaded = (m_phase == P_HOLD) && (nxt == P_HOLD);
        if (nxt == P_CLEAR) m_stall = 0;
        else if (exp_ready && !vl && m_stall < 65535) m_stall++;
        if (m_clr) begin m_cnt = 0; m_beats.delete(); m_set_valid = 0; end
        else if (acc) m_cnt++;
        if (m_loaded) m_set_valid = 1;
        m_phase = nxt;
        @(posedge clk); #1;
        check("wreg_en", o_wreg_en, m_en);
        check("wreg_clr", o_wreg_clr, m_clr);
        check("wreg_data", o_wreg_data, m_data);
        check("row_idx", o_row_idx, m_cnt);
        check("busy", o_busy, (m_phase == P_CLEAR) || (m_phase == P_LOAD));
        check("loaded", o_loaded, m_loaded);
`ifdef WREG_LOAD_CTRL_PERF_EN
        check("stall_cnt", o_stall_cnt, m_stall);
`endif
        if (m_set_valid) check_chain("chain");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, o_w_ready, 0);
        check({tag, "_en"},    o_wreg_en, 0);
        check({tag, "_clr"},   o_wreg_clr, 0);
        check({tag, "_data"},  o_wreg_data, 0);
        check({tag, "_idx"},   o_row_idx, 0);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_loaded"}, o_loaded, 0);
`ifdef WREG_LOAD_CTRL_PERF_EN
        check({tag, "_stall"}, o_stall_cnt, 0);
`endif
    endtask

    // Asserts reset away from any clock edge and checks outputs drop at once.
    task automatic reset_now(input string tag);
        i_start = 0; i_abort = 0; i_release = 0; i_w_valid = 0;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_all_zero({tag, "_post"});
    endtask

    task automatic idle(output bit r);
        cycle(0, 0, 0, 0, '0, r);
    endtask

    // ---------------- table of vectors for a basic load ----------------
    typedef struct {
        bit st, ab, rl, vl;
        logic [WIDTH-1:0] d;
        bit e_rdy, e_en, e_clr;
        logic [WIDTH-1:0] e_data;
        int e_idx;
        bit e_busy, e_loaded;
    } vec_t;

    function automatic vec_t mk(bit st, bit rl, bit vl, logic [WIDTH-1:0] d, bit e_rdy, bit e_en,
                                bit e_clr, logic [WIDTH-1:0] e_data, int e_idx, bit e_busy, bit e_loaded);
        vec_t v;
        v.st = st; v.ab = 0; v.rl = rl; v.vl = vl; v.d = d;
        v.e_rdy = e_rdy; v.e_en = e_en; v.e_clr = e_clr; v.e_data = e_data;
        v.e_idx = e_idx; v.e_busy = e_busy; v.e_loaded = e_loaded;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        bit   r;

        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0));   // -> CLEAR
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0));   // -> LOAD
        for (int k = 1; k <= ROWS; k++)
            vecs.push_back(mk(0, 0, 1, WIDTH'(k), 1, 1, 0, WIDTH'(k), k, k < ROWS, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 8, 8, 0, 1));   // loaded 2 cycles after 8th accept
        vecs.push_back(mk(0, 0, 1, 99, 0, 0, 0, 8, 8, 0, 1));   // beat ignored in HOLD
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 8, 8, 0, 0));   // release: no clr

        // ---- reset state ----
        reset_now("reset");

        // ---- basic load from the table ----
        foreach (vecs[i]) begin
            cycle(vecs[i].st, vecs[i].ab, vecs[i].rl, vecs[i].vl, vecs[i].d, r);
            check($sformatf("vec%0d_ready", i), r, vecs[i].e_rdy);
            check($sformatf("vec%0d_en", i), o_wreg_en, vecs[i].e_en);
            check($sformatf("vec%0d_clr", i), o_wreg_clr, vecs[i].e_clr);
            check($sformatf("vec%0d_data", i), o_wreg_data, vecs[i].e_data);
            check($sformatf("vec%0d_idx", i), o_row_idx, vecs[i].e_idx);
            check($sformatf("vec%0d_busy", i), o_busy, vecs[i].e_busy);
            check($sformatf("vec%0d_loaded", i), o_loaded, vecs[i].e_loaded);
        end
        check("basic_chain_head", chain[0], 8);
        check("basic_chain_tail", chain[ROWS-1], 1);
        idle(r);
        check("release_chain_kept", chain[0], 8);

        // ---- gapped valid ----
        cycle(1, 0, 0, 0, '0, r);
        idle(r);
        for (int i = 0; i < 2 * ROWS - 1; i++) begin
            cycle(0, 0, 0, (i % 2) == 0, WIDTH'(16'h100 + i), r);
            check("gap_idx_step", o_row_idx, (i / 2) + 1);
        end
        check("gap_idx_final", o_row_idx, ROWS);
`ifdef WREG_LOAD_CTRL_PERF_EN
        check("gap_stall_cnt", o_stall_cnt, 7);
`endif
        idle(r);
        check("gap_loaded", o_loaded, 1);
        cycle(0, 0, 1, 0, '0, r);

        // ---- abort mid-load ----
        cycle(1, 0, 0, 0, '0, r);
        idle(r);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, WIDTH'(16'h300 + k), r);
        cycle(0, 1, 0, 1, 16'h3ff, r);
        check("abort_ready_in_cycle", r, 0);
        check("abort_clr", o_wreg_clr, 1);
        check("abort_en", o_wreg_en, 0);
        check("abort_idx", o_row_idx, 0);
        check("abort_busy", o_busy, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 16'h3aa, r);
            check("abort_no_ready", r, 0);
            check("abort_clr_once", o_wreg_clr, 0);
        end

        // ---- reload priority: start + release in HOLD ----
        cycle(1, 0, 0, 0, '0, r);
        idle(r);
        for (int k = 0; k < ROWS; k++) cycle(0, 0, 0, 1, WIDTH'(16'h400 + k), r);
        idle(r);
        check("reload_pre_loaded", o_loaded, 1);
        cycle(1, 0, 1, 0, '0, r);
        check("reload_clr", o_wreg_clr, 1);
        check("reload_busy", o_busy, 1);
        check("reload_loaded_drop", o_loaded, 0);
        idle(r);
        for (int k = 0; k < ROWS; k++) cycle(0, 0, 0, 1, WIDTH'(16'hf000 + k), r);
        idle(r);
        check("reload_loaded", o_loaded, 1);
        check("reload_chain_head", chain[0], 16'hf007);
        check("reload_chain_tail", chain[ROWS-1], 16'hf000);

        // ---- async reset mid-load ----
        cycle(1, 0, 0, 0, '0, r);
        idle(r);
        cycle(0, 0, 0, 1, 16'h0555, r);
        cycle(0, 0, 0, 1, 16'h0666, r);
        #2;
        reset_now("areset");
        cycle(0, 0, 0, 1, 16'h0777, r);
        check("areset_idle_no_ready", r, 0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
                  WIDTH'($urandom), r);
        end

`ifdef WREG_LOAD_CTRL_PERF_EN
        // ---- stall counter saturation ----
        cycle(0, 1, 0, 0, '0, r);
        cycle(1, 0, 0, 0, '0, r);
        idle(r);
        for (int n = 0; n < 65540; n++) idle(r);
        check("stall_saturated", o_stall_cnt, 16'hffff);
        cycle(0, 1, 0, 0, '0, r);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wreg_load_ctrl

// File: doc/wreg_load_ctrl.md
Name: wreg_load_ctrl

Overview:
Sequences weight loading into one systolic-array column of weight registers wired as a shift chain (shared en/clr/data).
- Accepts ROWS weight beats from a weight source over a valid/ready handshake.
- Clears the column before loading, then shifts the beats in.
- Flags when the weights are stable for compute and holds them until compute releases the column.

Parameters:
WIDTH, 16, weight data width (signed)
ROWS, 8, number of weight registers in the column (>=2)
IDX_W, $clog2(ROWS+1), width of beat counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_start  input  1  request a (re)load of the column
i_abort  input  1  abandon the current operation and clear the column
i_release  input  1  compute finished with the loaded weights
i_w_valid  input  1  weight beat valid
i_w_data  input  WIDTH  weight beat (signed)
o_w_ready  output  1  controller accepts a beat
o_wreg_en  output  1  shift enable to the weight-register chain
o_wreg_clr  output  1  synchronous clear to the weight-register chain
o_wreg_data  output  WIDTH  data into the head of the chain (signed)
o_row_idx  output  IDX_W  beats accepted in the current load
o_busy  output  1  state is CLEAR or LOAD
o_loaded  output  1  column holds a complete, stable weight set

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0, including counters and o_wreg_data.
- FSM states: IDLE, CLEAR, LOAD, HOLD.
- Abort:
  - i_abort has top priority in every state.
  - Next state is IDLE; o_wreg_clr=1 for exactly one cycle after the abort edge.
  - o_wreg_en=0, o_row_idx=0, o_loaded=0.
- IDLE:
  - i_start -> CLEAR.
  - i_release is ignored.
- CLEAR (one cycle):
  - o_wreg_clr=1, o_w_ready=0, o_row_idx reset to 0.
  - -> LOAD.
- LOAD:
  - o_w_ready=1 while o_row_idx<ROWS.
  - A beat is accepted when i_w_valid && o_w_ready.
  - Registered output stage: a beat accepted in cycle t gives o_wreg_en=1 and o_wreg_data=i_w_data in cycle t+1. Otherwise o_wreg_en=0 and o_wreg_data holds.
  - o_row_idx increments on each accept.
  - On the ROWS-th accept -> HOLD, with o_w_ready=0 from the next cycle.
  - i_start is ignored in LOAD.
  - i_w_valid gaps stall the load with no timeout.
- HOLD:
  - o_loaded=1 from the cycle after HOLD entry, once the final shift has landed, and stays high while in HOLD.
  - o_w_ready=0; o_wreg_en=0 apart from the final beat's t+1 cycle.
  - i_start -> CLEAR, which reloads the column.
  - i_release -> IDLE with no clear; the registers keep their weights and o_loaded drops.
  - i_start and i_release in the same cycle: start wins.
- o_busy = state in {CLEAR, LOAD}, decoded from registered state.
- o_wreg_clr and o_wreg_en are never high in the same cycle.
- First beat accepted = deepest row after ROWS shifts.

Optional Feature:
WREG_LOAD_CTRL_PERF_EN
- Defined: adds output o_stall_cnt (16 bits).
  - Counts LOAD cycles with o_w_ready=1 && i_w_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared on entering CLEAR and on reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package wreg_ctrl_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_HOLD} wreg_ctrl_state_t;
  - constant STALL_CNT_W=16.
- No sub-module: the FSM, beat counter and output register stage stay in one module.
- The weight registers themselves are instantiated by the column, not by this block.

Test Plan:
- Basic load, ROWS=8:
  - Stimulus: i_start, then 8 back-to-back beats 1..8.
  - Required: o_wreg_clr high 1 cycle; o_wreg_en high 8 consecutive cycles with data 1..8; o_loaded high 2 cycles after the 8th accept; a model chain holds 8 at the head and 1 at the tail.
- Gapped valid:
  - Stimulus: beats with i_w_valid toggling 1,0,1,0.
  - Required: o_wreg_en pulses only after accepts; o_row_idx steps 0..8; with PERF_EN, o_stall_cnt=7.
- Abort mid-load:
  - Stimulus: i_abort after 3 beats.
  - Required: next cycle o_wreg_clr=1, state IDLE, o_row_idx=0, o_busy=0; later beats get no ready.
- Release:
  - Stimulus: i_release in HOLD.
  - Required: o_loaded falls next cycle, no clr pulse, chain contents unchanged.
- Reload priority:
  - Stimulus: i_start and i_release together in HOLD.
  - Required: CLEAR entered (clr pulse) and a new load of 8 beats.
- Async reset:
  - Stimulus: rst_n low mid-LOAD, between clock edges.
  - Required: all outputs 0 immediately; IDLE after release of reset.
